inst_fetch_queue: RTL and testbench

- Circular instruction buffer between the fetch stage (instruction RAM read via the RAM helper) and the decode/issue stage of the single-, two- and three-issue cores.
- Accepts up to ISSUE_NUM consecutive instructions per cycle from fetch.
- Presents the oldest ISSUE_NUM entries to decode, which consumes 0..ISSUE_NUM per cycle.
- Decouples fetch bandwidth from issue stalls and supports a full flush on redirect.

---
 rtl/core_pkg.sv | 13 +
 rtl/fq_ptr_ctrl.sv | 57 +++++
 rtl/inst_fetch_queue.sv | 91 +++++++++
 tb/tb_inst_fetch_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants and the instruction-slot type used between fetch and decode.
package core_pkg;

    localparam int PC_W          = 64;
    localparam int INST_W        = 32;
    localparam int ISSUE_NUM_MAX = 3;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } slot_t;

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Head/tail/count bookkeeping for the fetch queue: wrap arithmetic, ready/valid
// generation and reset/flush priority.
module fq_ptr_ctrl #(
    parameter int ISSUE_NUM = 2,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [1:0]               enq_cnt,
    input  logic [1:0]               deq_take,
    output logic                     enq_fire,
    output logic                     enq_ready,
    output logic [$clog2(DEPTH)-1:0] head,
    output logic [$clog2(DEPTH)-1:0] tail,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ISSUE_NUM-1:0]     deq_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          legal;
    logic [CW-1:0] enq_n;
    logic [CW-1:0] take;

    assign legal     = (enq_cnt != 2'd0) && (int'(enq_cnt) <= ISSUE_NUM);
    // Ready looks only at the registered count, so a same-cycle dequeue never
    // lets an enqueue overrun the storage.
    assign enq_ready = (CW'(DEPTH) - count) >= CW'(ISSUE_NUM);
    assign enq_fire  = enq_valid & enq_ready & ~flush & legal;
    assign enq_n     = enq_fire ? CW'(enq_cnt) : '0;
    assign take      = (CW'(deq_take) > count) ? count : CW'(deq_take);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + take[PW-1:0];
            tail  <= tail + enq_n[PW-1:0];
            count <= count + enq_n - take;
        end
    end

    for (genvar i = 0; i < ISSUE_NUM; i++) begin : g_vld
        assign deq_valid[i] = count > CW'(i);
    end

    always_ff @(posedge clk) begin
        if (rst && enq_valid)
            assert (legal);
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular instruction buffer between fetch and decode: up to ISSUE_NUM in and out per cycle.
// Optional INST_FETCH_QUEUE_PERF_EN adds full-stall and empty cycle counters.
module inst_fetch_queue
    import core_pkg::*;
#(
    parameter int ISSUE_NUM = 2,
    parameter int DEPTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        enq_valid,
    input  logic [1:0]                  enq_cnt,
    input  logic [PC_W-1:0]             enq_pc,
    input  logic [ISSUE_NUM*INST_W-1:0] enq_inst,
    output logic                        enq_ready,
    output logic [ISSUE_NUM-1:0]        deq_valid,
    output logic [ISSUE_NUM*PC_W-1:0]   deq_pc,
    output logic [ISSUE_NUM*INST_W-1:0] deq_inst,
    input  logic [1:0]                  deq_take,
    output logic [$clog2(DEPTH):0]      count
`ifdef INST_FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]                 perf_stall_full,
    output logic [31:0]                 perf_empty
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          enq_fire;
    slot_t         mem [DEPTH];

    fq_ptr_ctrl #(
        .ISSUE_NUM (ISSUE_NUM),
        .DEPTH     (DEPTH)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_cnt   (enq_cnt),
        .deq_take  (deq_take),
        .enq_fire  (enq_fire),
        .enq_ready (enq_ready),
        .head      (head),
        .tail      (tail),
        .count     (count),
        .deq_valid (deq_valid)
    );

    // Storage is intentionally not reset; deq_valid qualifies every read lane.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ISSUE_NUM; i++) begin
            if (enq_fire && (i < int'(enq_cnt))) begin
                mem[tail + PW'(i)] <= '{pc: enq_pc + PC_W'(4 * i),
                                        inst: enq_inst[i*INST_W +: INST_W]};
            end
        end
    end

    for (genvar i = 0; i < ISSUE_NUM; i++) begin : g_lane
        slot_t rd;
        assign rd                          = mem[head + PW'(i)];
        assign deq_pc[i*PC_W +: PC_W]      = rd.pc;
        assign deq_inst[i*INST_W +: INST_W] = rd.inst;
    end

`ifdef INST_FETCH_QUEUE_PERF_EN
    logic [31:0] stall_full_cycles;
    logic [31:0] empty_cycles;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_full_cycles <= '0;
            empty_cycles      <= '0;
        end else begin
            if (enq_valid && !enq_ready && (stall_full_cycles != '1))
                stall_full_cycles <= stall_full_cycles + 32'd1;
            if ((count == '0) && !flush && (empty_cycles != '1))
                empty_cycles <= empty_cycles + 32'd1;
        end
    end

    assign perf_stall_full = stall_full_cycles;
    assign perf_empty      = empty_cycles;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed scoreboard bench for inst_fetch_queue (ISSUE_NUM=2, DEPTH=8).
module tb_inst_fetch_queue;
    import core_pkg::*;

    localparam int ISSUE_NUM = 2;
    localparam int DEPTH     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic [1:0]  enq_cnt = 2'd0;
    logic [63:0] enq_pc = '0;
    logic [63:0] enq_inst = '0;
    logic [1:0]  deq_take = 2'd0;
    logic        enq_ready;
    logic [1:0]  deq_valid;
    logic [127:0] deq_pc;
    logic [63:0] deq_inst;
    logic [3:0]  count;
`ifdef INST_FETCH_QUEUE_PERF_EN
    logic [31:0] perf_stall_full;
    logic [31:0] perf_empty;
`endif

    slot_t sbq[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic [2:0] h0;

    inst_fetch_queue #(.ISSUE_NUM(ISSUE_NUM), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_cnt   (enq_cnt),
        .enq_pc    (enq_pc),
        .enq_inst  (enq_inst),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_inst  (deq_inst),
        .deq_take  (deq_take),
        .count     (count)
`ifdef INST_FETCH_QUEUE_PERF_EN
        ,
        .perf_stall_full (perf_stall_full),
        .perf_empty      (perf_empty)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check current outputs against the model, then advance the model.
    task automatic cyc(input bit ev, input logic [1:0] cnt, input logic [63:0] pc,
                       input logic [1:0] take, input bit fl);
        int    sz;
        int    eff;
        bit    fire;
        slot_t s;
        enq_valid = ev;
        enq_cnt   = cnt;
        enq_pc    = pc;
        deq_take  = take;
        flush     = fl;
        enq_inst  = {$urandom, $urandom};
        #1;
        sz = sbq.size();
        chk("count", 64'(count), 64'(sz));
        chk("deq_valid", 64'(deq_valid), {62'b0, sz > 1, sz > 0});
        chk("enq_ready", 64'(enq_ready), 64'((DEPTH - sz) >= ISSUE_NUM));
        for (int i = 0; i < ISSUE_NUM && i < sz; i++) begin
            chk("deq_pc", deq_pc[i*64 +: 64], sbq[i].pc);
            chk("deq_inst", 64'(deq_inst[i*32 +: 32]), 64'(sbq[i].inst));
        end
        fire = ev && ((DEPTH - sz) >= ISSUE_NUM) && !fl;
        if (fl) begin
            sbq.delete();
        end else begin
            eff = (int'(take) > sz) ? sz : int'(take);
            repeat (eff) void'(sbq.pop_front());
            if (fire) begin
                for (int i = 0; i < int'(cnt); i++) begin
                    s.pc   = pc + 64'(4 * i);
                    s.inst = enq_inst[i*32 +: 32];
                    sbq.push_back(s);
                end
            end
        end
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
        enq_cnt   = 2'd0;
        deq_take  = 2'd0;
        flush     = 1'b0;
    endtask

    initial begin
        // 1: reset then idle
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("t1_deq_valid", 64'(deq_valid), 64'd0);
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_enq_ready", 64'(enq_ready), 64'd1);
        cyc(0, 2'd0, 64'd0, 2'd0, 0);

        // 2: enqueue two beats, then drain
        cyc(1, 2'd2, 64'h8000_0000, 2'd0, 0);
        cyc(1, 2'd2, 64'h8000_0008, 2'd0, 0);
        chk("t2_count", 64'(count), 64'd4);
        chk("t2_pc0", deq_pc[63:0], 64'h8000_0000);
        chk("t2_pc1", deq_pc[127:64], 64'h8000_0004);
        chk("t2_valid", 64'(deq_valid), 64'd3);
        cyc(0, 2'd0, 64'd0, 2'd2, 0);
        cyc(0, 2'd0, 64'd0, 2'd2, 0);
        chk("t2_drained", 64'(count), 64'd0);

        // 3: fill to full, reject, free up
        cyc(1, 2'd2, 64'h200, 2'd0, 0);
        cyc(1, 2'd2, 64'h208, 2'd0, 0);
        cyc(1, 2'd2, 64'h210, 2'd0, 0);
        cyc(1, 2'd2, 64'h218, 2'd0, 0);
        chk("t3_full_count", 64'(count), 64'd8);
        chk("t3_full_ready", 64'(enq_ready), 64'd0);
        cyc(1, 2'd2, 64'h300, 2'd0, 0);
        chk("t3_reject_count", 64'(count), 64'd8);
        cyc(0, 2'd0, 64'd0, 2'd1, 0);
        chk("t3_7_ready", 64'(enq_ready), 64'd0);
        cyc(0, 2'd0, 64'd0, 2'd1, 0);
        chk("t3_6_ready", 64'(enq_ready), 64'd1);
        repeat (3) cyc(0, 2'd0, 64'd0, 2'd2, 0);
        chk("t3_empty", 64'(count), 64'd0);

        // 4: wrap across index 7 -> 0
        cyc(1, 2'd2, 64'h400, 2'd0, 0);
        cyc(1, 2'd1, 64'h408, 2'd0, 0);
        cyc(0, 2'd0, 64'd0, 2'd2, 0);
        cyc(0, 2'd0, 64'd0, 2'd1, 0);
        chk("t4_head", 64'(dut.u_ptr.head), 64'd7);
        chk("t4_tail", 64'(dut.u_ptr.tail), 64'd7);
        cyc(1, 2'd2, 64'h100, 2'd0, 0);
        chk("t4_mem7", dut.mem[7].pc, 64'h100);
        chk("t4_mem0", dut.mem[0].pc, 64'h104);
        chk("t4_pc0", deq_pc[63:0], 64'h100);
        chk("t4_pc1", deq_pc[127:64], 64'h104);

        // 5: simultaneous enq/deq, then flush with enqueue
        cyc(1, 2'd1, 64'h108, 2'd0, 0);
        chk("t5_count3", 64'(count), 64'd3);
        cyc(1, 2'd2, 64'h10c, 2'd2, 0);
        chk("t5_simul", 64'(count), 64'd3);
        cyc(1, 2'd2, 64'h500, 2'd0, 1);
        chk("t5_flush_count", 64'(count), 64'd0);
        chk("t5_flush_valid", 64'(deq_valid), 64'd0);
        chk("t5_flush_ready", 64'(enq_ready), 64'd1);
        cyc(1, 2'd1, 64'h600, 2'd0, 0);
        chk("t5_post_flush_pc", deq_pc[63:0], 64'h600);

        // 6: over-take clamps to count
        h0 = dut.u_ptr.head;
        cyc(0, 2'd0, 64'd0, 2'd2, 0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_head", 64'(dut.u_ptr.head), 64'(3'(h0 + 3'd1)));
        cyc(0, 2'd0, 64'd0, 2'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
